cg_shot_log: RTL and testbench
==============================

# cg_shot_log

Passive shot recorder on the coilgun core's output side. It watches the same trigger and gate strobes that `cg_core` consumes, plus the core's coil-drive output. For each shot it measures the trigger-to-fire delay and the coil on-time, and classifies why the pulse ended. Each completed shot becomes one record in a small first-word-fall-through FIFO, which a host or telemetry block pops with a valid/read handshake.

## Interface
- `P_W`, 24 — width of the delay and on-time counters; matches `cg_core` `I_LMT`/`I_DLY` width.
- `P_DEPTH`, 4 — FIFO depth in records; power of two, minimum 2.
- `P_TIMEOUT`, 24'hFFFFFF — armed-state cycle limit before a TIMEOUT record is logged.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `I_RST`  in  1  — asynchronous, active-high reset.
- `I_TRIG`  in  1  — shot trigger; same net as `cg_core` `I_TRIG`; synchronous to `clk`.
- `I_GATE`  in  1  — projectile gate sensor; same net as `cg_core` `I_GATE`.
- `I_EXT`  in  1  — coil drive; connected to `cg_core` `O_EXT`.
- `I_RD`  in  1  — pop request for the head record.
- `O_VLD`  out  1  — FIFO non-empty; the head record is on the `O_DLY`/`O_ON`/`O_CAUSE` outputs.
- `O_DLY`  out  P_W  — head record: trigger-to-fire delay in cycles.
- `O_ON`  out  P_W  — head record: coil on-time in cycles.
- `O_CAUSE`  out  2  — head record end cause: 0 LIMIT, 1 GATE, 2 TIMEOUT, 3 reserved (never produced).
- `O_FULL`  out  1  — FIFO holds `P_DEPTH` records.
- `O_OVF`  out  1  — sticky: a record was dropped. Cleared only by `I_RST`.
- `O_BUSY`  out  1  — FSM not in IDLE.

## Operation
Trigger rising edge:
- A rising edge is `I_TRIG` sampled high after being sampled low on the previous edge.
- The previous-`I_TRIG` register resets to 1, so a trigger held high through reset is not an edge.

FSM states: IDLE, ARMED, FIRING.
- IDLE → ARMED on a trigger rising edge. The delay counter and the gate flag clear.
- ARMED, `I_EXT` low: the delay counter increments, saturating at all-ones.
  - When the delay counter reaches `P_TIMEOUT`, push a record {`O_DLY` = `P_TIMEOUT`, `O_ON` = 0, `O_CAUSE` = TIMEOUT} and go to IDLE.
- ARMED → FIRING when `I_EXT` is sampled high. The on-time counter loads 1.
- FIRING, `I_EXT` high: the on-time counter increments, saturating.
  - `I_GATE` sampled high in any FIRING cycle sets the gate flag.
- FIRING → IDLE when `I_EXT` is sampled low. Push a record with cause GATE if the gate flag is set, else LIMIT.

Ignored events:
- Trigger edges while ARMED or FIRING; the counters are not restarted.
- `I_EXT` high while IDLE (no trigger seen); no record is made.
- `I_GATE` outside FIRING.

FIFO:
- The head record is always presented on the outputs while `O_VLD` is high.
- `I_RD` with `O_VLD` high pops the head. `I_RD` with `O_VLD` low is ignored.
- A push while full with no pop in the same cycle drops the new record and sets `O_OVF`. FIFO contents are unchanged.
- Push and pop in the same cycle while full: both succeed, no overflow.
- Push and pop in the same cycle while empty: only the push takes effect, since `O_VLD` was low.
- Read and write pointers wrap modulo `P_DEPTH`. Occupancy is tracked with an extra pointer bit or a count.

## Timing
- Reset values: FSM IDLE; counters 0; FIFO empty.
  - `O_VLD` = 0, `O_FULL` = 0, `O_OVF` = 0, `O_BUSY` = 0.
  - `O_DLY`, `O_ON`, `O_CAUSE` = 0.
- Reset asserted mid-shot or with the FIFO occupied clears everything immediately. No record is emitted.
- `O_BUSY` rises on the edge that samples the trigger rising edge.
- `O_DLY` = number of rising edges from the trigger-edge sample to the first edge sampling `I_EXT` high. Example: `I_EXT` first sampled high 5 edges after the trigger edge gives `O_DLY` = 5.
- `O_ON` = number of edges sampling `I_EXT` high.
- Push latency: `O_VLD`, the head data and `O_BUSY` = 0 all update on the edge that samples `I_EXT` low, or on the timeout edge.
- A new trigger edge can be accepted on the cycle after the push edge.
- Pop: head data advances on the edge where `I_RD` && `O_VLD`. `O_VLD` falls on that same edge if it was the last record.
- `O_FULL` and `O_OVF` are registered and update on the same edge as the push or pop that changes them.

## Test plan
- Basic shot: trigger pulse; `I_EXT` high from edge 5 to edge 16 after the trigger edge, `I_GATE` low → one record, `O_DLY` = 5, `O_ON` = 12, `O_CAUSE` = 0. `O_BUSY` low after the fall.
- Gate termination: same as basic shot, with `I_GATE` high for 3 cycles mid-pulse → `O_CAUSE` = 1, counts unchanged. `I_GATE` before `I_EXT` rises → `O_CAUSE` = 0.
- Timeout with `P_TIMEOUT` = 100: trigger, `I_EXT` never rises → record {100, 0, 2} one hundred edges after the trigger edge. A later `I_EXT` pulse produces no record.
- Overflow with `P_DEPTH` = 4: five shots, no reads → `O_FULL` after the 4th shot, `O_OVF` = 1 after the 5th. Four pops return shots 1–4 in order. `O_OVF` stays 1.
- Simultaneous push/pop when full: `I_RD` asserted on the push edge of shot 5 → no overflow, `O_FULL` stays 1. Reads yield shots 2–5.
- Reset mid-FIRING with 2 records queued → all outputs return to reset values immediately. The next shot logs correctly. A retrigger during ARMED does not restart `O_DLY`.

Source files
------------

// File: rtl/cg_shot_log.sv
// Passive coilgun shot recorder: measures trigger-to-fire delay and coil on-time per shot,
// classifies the end cause and queues one record per shot in a first-word-fall-through FIFO.
module cg_shot_log #(
    parameter int unsigned     P_W       = 24,
    parameter int unsigned     P_DEPTH   = 4,
    parameter logic [P_W-1:0]  P_TIMEOUT = {P_W{1'b1}}
) (
    input  logic           clk,
    input  logic           I_RST,
    input  logic           I_TRIG,
    input  logic           I_GATE,
    input  logic           I_EXT,
    input  logic           I_RD,
    output logic           O_VLD,
    output logic [P_W-1:0] O_DLY,
    output logic [P_W-1:0] O_ON,
    output logic [1:0]     O_CAUSE,
    output logic           O_FULL,
    output logic           O_OVF,
    output logic           O_BUSY
);

    localparam int unsigned AW = $clog2(P_DEPTH);
    localparam int unsigned RW = 2 * P_W + 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_FIRING = 2'd2;

    localparam logic [1:0] CAUSE_LIMIT   = 2'd0;
    localparam logic [1:0] CAUSE_GATE    = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    logic [1:0]     state_q, state_d;
    logic           trig_prev_q, trig_prev_d;
    logic [P_W-1:0] dly_q, dly_d;
    logic [P_W-1:0] on_q, on_d;
    logic           gate_q, gate_d;
    logic           ovf_q, ovf_d;
    logic           full_q, full_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]  mem_q [P_DEPTH];

    logic           trig_edge;
    logic [P_W-1:0] dly_inc;
    logic [P_W-1:0] on_inc;
    logic           push;
    logic [RW-1:0]  rec;
    logic           vld;
    logic           pop;
    logic           wr_en;
    logic [RW-1:0]  head;

    assign trig_edge = I_TRIG & ~trig_prev_q;
    assign dly_inc   = (dly_q == {P_W{1'b1}}) ? dly_q : dly_q + P_W'(1);
    assign on_inc    = (on_q == {P_W{1'b1}}) ? on_q : on_q + P_W'(1);

    // The delay counter also advances on the edge that first sees I_EXT high, so the
    // recorded delay counts edges from the trigger sample up to and including that one.
    always_comb begin
        state_d     = state_q;
        trig_prev_d = I_TRIG;
        dly_d       = dly_q;
        on_d        = on_q;
        gate_d      = gate_q;
        push        = 1'b0;
        rec         = '0;
        case (state_q)
            ST_IDLE: begin
                if (trig_edge) begin
                    state_d = ST_ARMED;
                    dly_d   = '0;
                    on_d    = '0;
                    gate_d  = 1'b0;
                end
            end
            ST_ARMED: begin
                dly_d = dly_inc;
                if (I_EXT) begin
                    state_d = ST_FIRING;
                    on_d    = P_W'(1);
                end else if (dly_inc == P_TIMEOUT) begin
                    state_d = ST_IDLE;
                    push    = 1'b1;
                    rec     = {P_TIMEOUT, {P_W{1'b0}}, CAUSE_TIMEOUT};
                end
            end
            ST_FIRING: begin
                if (I_EXT) begin
                    on_d = on_inc;
                    if (I_GATE) begin
                        gate_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    push    = 1'b1;
                    rec     = {dly_q, on_q, (gate_q | I_GATE) ? CAUSE_GATE : CAUSE_LIMIT};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign vld   = (wr_ptr_q != rd_ptr_q);
    assign pop   = I_RD & vld;
    // When full, a push only lands if the head slot is being freed on the same edge.
    assign wr_en = push & (~full_q | pop);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        ovf_d    = ovf_q | (push & full_q & ~pop);
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state_q     <= ST_IDLE;
            trig_prev_q <= 1'b1;
            dly_q       <= '0;
            on_q        <= '0;
            gate_q      <= 1'b0;
            ovf_q       <= 1'b0;
            full_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= trig_prev_d;
            dly_q       <= dly_d;
            on_q        <= on_d;
            gate_q      <= gate_d;
            ovf_q       <= ovf_d;
            full_q      <= full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            for (int i = 0; i < int'(P_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rec;
        end
    end

    assign O_VLD   = vld;
    assign O_DLY   = vld ? head[RW-1 -: P_W] : '0;
    assign O_ON    = vld ? head[P_W+1 -: P_W] : '0;
    assign O_CAUSE = vld ? head[1:0] : 2'd0;
    assign O_FULL  = full_q;
    assign O_OVF   = ovf_q;
    assign O_BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cg_shot_log.sv
// Scoreboard bench for cg_shot_log: stimulus queues expected records, a negedge monitor
// compares the head record on every accepted pop.
module tb_cg_shot_log;

    typedef struct packed {
        logic [23:0] d;
        logic [23:0] o;
        logic [1:0]  c;
    } rec_t;

    logic        clk = 1'b0;
    logic        I_RST = 1'b1;
    logic        I_TRIG = 1'b0;
    logic        I_GATE = 1'b0;
    logic        I_EXT = 1'b0;
    logic        I_RD = 1'b0;
    logic        O_VLD;
    logic [23:0] O_DLY;
    logic [23:0] O_ON;
    logic [1:0]  O_CAUSE;
    logic        O_FULL;
    logic        O_OVF;
    logic        O_BUSY;

    int   total = 0;
    int   bad = 0;
    rec_t exp_q[$];

    cg_shot_log #(
        .P_W      (24),
        .P_DEPTH  (4),
        .P_TIMEOUT(24'd100)
    ) dut (
        .clk    (clk),
        .I_RST  (I_RST),
        .I_TRIG (I_TRIG),
        .I_GATE (I_GATE),
        .I_EXT  (I_EXT),
        .I_RD   (I_RD),
        .O_VLD  (O_VLD),
        .O_DLY  (O_DLY),
        .O_ON   (O_ON),
        .O_CAUSE(O_CAUSE),
        .O_FULL (O_FULL),
        .O_OVF  (O_OVF),
        .O_BUSY (O_BUSY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        rec_t got;
        if (!I_RST && O_VLD && I_RD) begin
            got = '{d: O_DLY, o: O_ON, c: O_CAUSE};
            if (exp_q.size() == 0) begin
                chk("unexpected_record", 64'(got), 64'hdead);
            end else begin
                r = exp_q.pop_front();
                chk("record", 64'(got), 64'(r));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        I_RST  = 1'b1;
        I_TRIG = 1'b0;
        I_GATE = 1'b0;
        I_EXT  = 1'b0;
        I_RD   = 1'b0;
        exp_q.delete();
        tick();
        I_RST = 1'b0;
        tick();
    endtask

    // gmode: 0 no gate, 1 gate during pulse, 2 gate only while armed
    task automatic shot(input int d, input int on, input int gmode, input bit retrig,
                        input bit rd_on_push, input bit drop);
        if (!drop) begin
            exp_q.push_back('{d: 24'(d), o: 24'(on), c: (gmode == 1) ? 2'd1 : 2'd0});
        end
        I_TRIG = 1'b1;
        tick();
        I_TRIG = 1'b0;
        chk("busy_armed", 64'(O_BUSY), 64'd1);
        for (int i = 1; i < d; i++) begin
            I_GATE = (gmode == 2);
            I_TRIG = retrig && (i == 1);
            tick();
        end
        I_TRIG = 1'b0;
        I_GATE = 1'b0;
        I_EXT  = 1'b1;
        for (int i = 0; i < on; i++) begin
            I_GATE = (gmode == 1) && (i >= 3) && (i < 6);
            tick();
        end
        I_GATE = 1'b0;
        I_EXT  = 1'b0;
        I_RD   = rd_on_push;
        tick();
        I_RD = 1'b0;
        chk("busy_after_push", 64'(O_BUSY), 64'd0);
    endtask

    task automatic pop(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!O_VLD && t < 50) begin
                tick();
                t++;
            end
            if (!O_VLD) begin
                chk("pop_wait_vld", 64'(O_VLD), 64'd1);
            end else begin
                I_RD = 1'b1;
                tick();
                I_RD = 1'b0;
            end
        end
    endtask

    initial begin
        I_TRIG = 1'b1;
        tick();
        tick();
        chk("rst_vld", 64'(O_VLD), 64'd0);
        chk("rst_full", 64'(O_FULL), 64'd0);
        chk("rst_ovf", 64'(O_OVF), 64'd0);
        chk("rst_busy", 64'(O_BUSY), 64'd0);
        chk("rst_data", {O_DLY, O_ON, O_CAUSE}, 64'd0);
        // Trigger held high across reset release must not start a shot
        I_RST = 1'b0;
        tick();
        tick();
        chk("held_trig_busy", 64'(O_BUSY), 64'd0);
        I_TRIG = 1'b0;
        tick();

        shot(5, 12, 0, 1'b0, 1'b0, 1'b0);
        chk("basic_vld", 64'(O_VLD), 64'd1);
        pop(1);
        shot(5, 12, 1, 1'b0, 1'b0, 1'b0);
        shot(5, 12, 2, 1'b0, 1'b0, 1'b0);
        pop(2);
        chk("sb_empty_a", 64'(exp_q.size()), 64'd0);

        exp_q.push_back('{d: 24'd100, o: 24'd0, c: 2'd2});
        I_TRIG = 1'b1;
        tick();
        I_TRIG = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        chk("to_before_vld", 64'(O_VLD), 64'd0);
        chk("to_before_busy", 64'(O_BUSY), 64'd1);
        tick();
        chk("to_vld", 64'(O_VLD), 64'd1);
        chk("to_busy", 64'(O_BUSY), 64'd0);
        pop(1);
        I_EXT = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        I_EXT = 1'b0;
        tick();
        chk("idle_ext_busy", 64'(O_BUSY), 64'd0);
        chk("idle_ext_vld", 64'(O_VLD), 64'd0);

        do_reset();
        for (int i = 1; i <= 5; i++) begin
            shot(i + 2, i + 3, 0, 1'b0, 1'b0, i == 5);
            if (i == 3) chk("full_after3", 64'(O_FULL), 64'd0);
            if (i == 4) begin
                chk("full_after4", 64'(O_FULL), 64'd1);
                chk("ovf_after4", 64'(O_OVF), 64'd0);
            end
        end
        chk("ovf_after5", 64'(O_OVF), 64'd1);
        chk("full_after5", 64'(O_FULL), 64'd1);
        pop(4);
        chk("ovf_sticky", 64'(O_OVF), 64'd1);
        chk("ovf_empty_vld", 64'(O_VLD), 64'd0);
        chk("ovf_empty_full", 64'(O_FULL), 64'd0);
        chk("sb_empty_b", 64'(exp_q.size()), 64'd0);

        do_reset();
        for (int i = 1; i <= 4; i++) shot(i + 2, i + 3, 0, 1'b0, 1'b0, 1'b0);
        chk("sim_full_before", 64'(O_FULL), 64'd1);
        shot(7, 8, 1, 1'b0, 1'b1, 1'b0);
        chk("sim_full_after", 64'(O_FULL), 64'd1);
        chk("sim_ovf", 64'(O_OVF), 64'd0);
        chk("sim_depth", 64'(exp_q.size()), 64'd4);
        pop(4);
        chk("sim_empty_vld", 64'(O_VLD), 64'd0);

        do_reset();
        shot(3, 4, 0, 1'b0, 1'b0, 1'b0);
        shot(4, 5, 1, 1'b0, 1'b0, 1'b0);
        I_TRIG = 1'b1;
        tick();
        I_TRIG = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        I_EXT = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_busy", 64'(O_BUSY), 64'd1);
        I_RST = 1'b1;
        #1;
        chk("mid_rst_vld", 64'(O_VLD), 64'd0);
        chk("mid_rst_busy", 64'(O_BUSY), 64'd0);
        chk("mid_rst_flags", {O_FULL, O_OVF}, 64'd0);
        chk("mid_rst_data", {O_DLY, O_ON, O_CAUSE}, 64'd0);
        exp_q.delete();
        I_EXT = 1'b0;
        tick();
        I_RST = 1'b0;
        tick();
        shot(6, 4, 0, 1'b1, 1'b0, 1'b0);
        pop(1);
        chk("sb_empty_end", 64'(exp_q.size()), 64'd0);
        chk("end_vld", 64'(O_VLD), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
